// File: rtl/dmem_if_pkg.sv
// Shared data-memory port definitions for bus initiators that borrow the CPU's
// single-cycle data-memory port.
package dmem_if_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 16;

    localparam logic [WORD_W-1:0] DMEM_ARRAY_BASE  = 32'd1000;
    localparam logic [WORD_W-1:0] DMEM_RESULT_BASE = 32'd2000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        WR_MAX = 3'd2,
        WR_IDX = 3'd3,
        FIN    = 3'd4
    } scan_state_t;

endpackage

// File: rtl/max_cmp_sel.sv
// Signed compare/select stage of the max scan. It keeps the running winner
// unless the candidate is the first element or strictly greater.
import dmem_if_pkg::*;

module max_cmp_sel (
    input  logic [WORD_W-1:0] cand,
    input  logic [IDX_W-1:0]  candIdx,
    input  logic              first,
    input  logic [WORD_W-1:0] runMax,
    input  logic [IDX_W-1:0]  runIdx,
    output logic [WORD_W-1:0] selMax,
    output logic [IDX_W-1:0]  selIdx
);

    logic takeCand;

    // Strict '>' so that ties keep the earliest index.
    assign takeCand = first || ($signed(cand) > $signed(runMax));
    assign selMax   = takeCand ? cand    : runMax;
    assign selIdx   = takeCand ? candIdx : runIdx;

endmodule

// File: rtl/max_scan_master.sv
// Data-memory bus initiator: scans COUNT words from BASE_ADDR for the signed
// maximum and writes the value and its index back to RESULT_ADDR / +4.
import dmem_if_pkg::*;

module max_scan_master #(
    parameter logic [WORD_W-1:0] BASE_ADDR   = DMEM_ARRAY_BASE,
    parameter int                COUNT       = 20,
    parameter logic [WORD_W-1:0] RESULT_ADDR = DMEM_RESULT_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] mem_adr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] max_value,
    output logic [WORD_W-1:0] max_index,
    output scan_state_t       dbgState
);

    if (COUNT < 1 || COUNT > 65535) begin : gBadCount
        $error("max_scan_master: COUNT must be in 1..65535");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : gBadBase
        $error("max_scan_master: BASE_ADDR must be word aligned");
    end
    if (RESULT_ADDR[1:0] != 2'b00) begin : gBadResult
        $error("max_scan_master: RESULT_ADDR must be word aligned");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

    scan_state_t       state, nextState;
    logic [IDX_W-1:0]  i;
    logic [WORD_W-1:0] runMax;
    logic [IDX_W-1:0]  runIdx;
    logic [WORD_W-1:0] selMax;
    logic [IDX_W-1:0]  selIdx;

    max_cmp_sel uCmp (
        .cand    (mem_rdata),
        .candIdx (i),
        .first   (i == '0),
        .runMax  (runMax),
        .runIdx  (runIdx),
        .selMax  (selMax),
        .selIdx  (selIdx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            runMax    <= '0;
            runIdx    <= '0;
            max_value <= '0;
            max_index <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        i      <= '0;
                        runMax <= '0;
                        runIdx <= '0;
                    end
                end
                SCAN: begin
                    runMax <= selMax;
                    runIdx <= selIdx;
                    if (i != LAST_IDX) begin
                        i <= i + 1'b1;
                    end
                end
                // Loaded on entry to FIN so the results are visible alongside done.
                WR_IDX: begin
                    max_value <= runMax;
                    max_index <= {{(WORD_W-IDX_W){1'b0}}, runIdx};
                end
                default: ;
            endcase
        end
    end

    // start/done handshake: start is a 1-cycle request honoured only in IDLE
    // (never queued); done is a 1-cycle pulse with results valid that cycle.
    always_comb begin
        nextState = state;
        mem_adr   = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = SCAN;
            end
            SCAN: begin
                mem_read = 1'b1;
                mem_adr  = BASE_ADDR + {{(WORD_W-IDX_W-2){1'b0}}, i, 2'b00};
                if (i == LAST_IDX) nextState = WR_MAX;
            end
            WR_MAX: begin
                mem_write = 1'b1;
                mem_adr   = RESULT_ADDR;
                mem_wdata = runMax;
                nextState = WR_IDX;
            end
            WR_IDX: begin
                mem_write = 1'b1;
                mem_adr   = RESULT_ADDR + 32'd4;
                mem_wdata = {{(WORD_W-IDX_W){1'b0}}, runIdx};
                nextState = FIN;
            end
            FIN: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign dbgState = state;

endmodule

// File: tb/tb_max_scan_master.sv
// Directed bench for max_scan_master with a behavioural data memory and a
// done-triggered scoreboard monitor.
import dmem_if_pkg::*;

module tb_max_scan_master;

    localparam int COUNT = 20;
    localparam int BASE_W = 250;   // word index of byte address 1000
    localparam int RES_W  = 500;   // word index of byte address 2000
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy, done;
    logic [31:0] max_value, max_index;
    scan_state_t dbgState;

    logic [31:0] mem [0:1023];

    logic [63:0] exp_q[$];
    int          expCyc_q[$];
    int          cyc = 0;
    int          nCompared = 0;
    int          nFail = 0;
    int          scanPos = 0;

    max_scan_master #(.BASE_ADDR(32'd1000), .COUNT(COUNT), .RESULT_ADDR(32'd2000)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .max_value (max_value),
        .max_index (max_index),
        .dbgState  (dbgState)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem_read ? mem[mem_adr[11:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) mem[mem_adr[11:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read && mem_write) check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
            if (busy !== (dbgState != IDLE)) check("busy_vs_idle", 32'(busy), 32'(dbgState != IDLE));
            if (dbgState == SCAN) begin
                check("scan_addr", mem_adr, 32'd1000 + 32'(4 * scanPos));
                scanPos++;
            end else begin
                scanPos = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    logic [63:0] e;
                    int ec;
                    e  = exp_q.pop_front();
                    ec = expCyc_q.pop_front();
                    check("max_value", max_value, e[63:32]);
                    check("max_index", max_index, e[31:0]);
                    check("mem_result_val", mem[RES_W], e[63:32]);
                    check("mem_result_idx", mem[RES_W+1], e[31:0]);
                    check("done_cycle", 32'(cyc), 32'(ec));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fillArray(input logic [31:0] fillVal);
        for (int k = 0; k < COUNT; k++) mem[BASE_W+k] = fillVal;
        mem[RES_W]   = SENT;
        mem[RES_W+1] = SENT;
    endtask

    // Accepting edge is the posedge after this negedge; done is expected after
    // COUNT SCAN edges plus WR_MAX and WR_IDX, i.e. edge accept+COUNT+2.
    task automatic startOp(input bit track, input logic [31:0] val, input logic [31:0] idx);
        @(negedge clk);
        start = 1'b1;
        if (track) begin
            exp_q.push_back({val, idx});
            expCyc_q.push_back(cyc + 1 + COUNT + 2);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            expCyc_q.delete();
        end
    endtask

    task automatic waitState(input scan_state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dbgState == s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("state_timeout", 32'(dbgState), 32'(s));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit ok;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_mem_adr", mem_adr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_busy_done", {30'h0, busy, done}, 32'h0);
        check("rst_max_value", max_value, 32'h0);
        check("rst_max_index", max_index, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: first-occurrence tie
        fillArray(32'h0);
        mem[BASE_W+0] = 32'd3;
        mem[BASE_W+1] = 32'd9;
        mem[BASE_W+2] = -32'sd4;
        mem[BASE_W+3] = 32'd9;
        mem[BASE_W+4] = 32'd7;
        startOp(1'b1, 32'd9, 32'd1);
        waitDrain(100);

        // 2: all negative, max -1 at the last element
        for (int k = 0; k < COUNT; k++) mem[BASE_W+k] = 32'(k - 20);
        mem[BASE_W+5] = 32'h8000_0000;
        mem[RES_W] = SENT; mem[RES_W+1] = SENT;
        startOp(1'b1, 32'hFFFF_FFFF, 32'd19);
        waitDrain(100);

        // 3: most positive first, most negative elsewhere
        fillArray(32'h8000_0000);
        mem[BASE_W+0] = 32'h7FFF_FFFF;
        startOp(1'b1, 32'h7FFF_FFFF, 32'd0);
        waitDrain(100);

        // 4: reset during WR_IDX suppresses the index write
        fillArray(32'h0);
        mem[BASE_W+1] = 32'd9;
        startOp(1'b0, 32'h0, 32'h0);
        waitState(WR_IDX, 100, ok);
        rst = 1'b1;
        #1;
        check("rst4_mem_write", 32'(mem_write), 32'h0);
        check("rst4_busy_done", {30'h0, busy, done}, 32'h0);
        check("rst4_mem_adr", mem_adr, 32'h0);
        check("rst4_max_value", max_value, 32'h0);
        check("rst4_max_index", max_index, 32'h0);
        @(posedge clk);
        #1;
        check("rst4_mem501", mem[RES_W+1], SENT);
        check("rst4_mem500", mem[RES_W], 32'd9);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 5: starts during SCAN and coincident with done are ignored
        fillArray(32'd1);
        mem[BASE_W+7]  = 32'd100;
        mem[BASE_W+12] = 32'd100;
        startOp(1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitState(FIN, 100, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_idle_after_done", 32'(dbgState), 32'(IDLE));
        repeat (5) @(negedge clk);
        check("t5_still_idle", 32'(busy), 32'h0);
        waitDrain(10);

        fillArray(32'd2);
        mem[BASE_W+19] = 32'd5;
        startOp(1'b1, 32'd5, 32'd19);
        waitDrain(100);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule
